dmem_arbiter: RTL and testbench

- Shares the single data memory between two requesters: port 0 is the core load/store path, port 1 is the debug/program loader.
- Arbitrates round-robin, issues at most one access per cycle, and routes read data back to the requester that issued it.
- Rejects misaligned word accesses locally, without touching memory.
- Sits between the core/loader and data_mem; the memory side uses data_mem's mem_read/mem_write/addr/write_data/read_data convention.

---
 rtl/dmem_arbiter_if.sv | 27 ++
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request ports packed
// side by side, plus the shared response channel.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          resp_valid;
    logic                resp_err;
    logic [DATA_W-1:0]   resp_rdata;

    // Requesters (core / loader) drive requests and sink responses.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    // The arbiter grants requests and produces responses.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core load/store
// path (port 0) and the debug/program loader (port 1). One access per cycle,
// misaligned word accesses are answered locally with an error pulse, and load
// data is routed back to the issuing port one cycle after the access.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter bit          PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     bus,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              last_q, last_d;
    logic              tag_valid_q, tag_valid_d;
    logic              tag_port_q, tag_port_d;
    logic              tag_err_q, tag_err_d;

    logic              accept;
    logic              grant;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              aligned;

    // Grant selection, memory issue and next-state for pointer and read tag.
    always_comb begin
        accept = 1'b0;
        grant  = 1'b0;
        if (reset) begin
            case (bus.req_valid)
                2'b01:   begin accept = 1'b1; grant = 1'b0;    end
                2'b10:   begin accept = 1'b1; grant = 1'b1;    end
                2'b11:   begin accept = 1'b1; grant = ~last_q; end
                default: begin accept = 1'b0; grant = 1'b0;    end
            endcase
        end

        sel_write = grant ? bus.req_write[1] : bus.req_write[0];
        sel_addr  = grant ? bus.req_addr[ADDR_W +: ADDR_W] : bus.req_addr[0 +: ADDR_W];
        sel_wdata = grant ? bus.req_wdata[DATA_W +: DATA_W] : bus.req_wdata[0 +: DATA_W];
        aligned   = (sel_addr[1:0] == 2'b00);

        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant] = 1'b1;
        end

        mem_read  = accept & aligned & ~sel_write;
        mem_write = accept & aligned & sel_write;
        mem_addr  = (accept && aligned) ? sel_addr : '0;
        mem_wdata = (accept && aligned && sel_write) ? sel_wdata : '0;

        last_d      = accept ? grant : last_q;
        tag_valid_d = accept & (~sel_write | ~aligned);
        tag_port_d  = grant;
        tag_err_d   = ~aligned;
    end

    // Responses are gated by reset so an in-flight load is dropped in the reset cycle itself.
    always_comb begin
        bus.resp_valid = '0;
        if (reset && tag_valid_q) begin
            bus.resp_valid[tag_port_q] = 1'b1;
        end
        bus.resp_err   = reset & tag_valid_q & tag_err_q;
        bus.resp_rdata = (reset && tag_valid_q && !tag_err_q) ? mem_rdata : '0;
    end

    // Last-grant pointer and one-entry response tag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q      <= ~PRIO_INIT;
            tag_valid_q <= 1'b0;
            tag_port_q  <= 1'b0;
            tag_err_q   <= 1'b0;
        end else begin
            last_q      <= last_d;
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            tag_err_q   <= tag_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a small registered
// data memory. Memory words are preloaded with 0xA500_0000 + word index.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [256];

    int unsigned checks;
    int unsigned errors;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_INIT(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory; a write in cycle N is visible to a read in N+1.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + 32'(i);
            mem_rdata <= '0;
        end else begin
            if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
            if (mem_read)  mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [1:0]  w;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        mrd;
        logic        mwr;
        logic [31:0] maddr;
        logic        adc;   // address/wdata not checked (misaligned accept)
        logic [31:0] mwd;
        logic [1:0]  rv;
        logic        rerr;
        logic [31:0] rdata;
    } row_t;

    row_t rows[$];

    task automatic add(input logic rst, input logic [1:0] v, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] rdy, input logic mrd, input logic mwr,
                       input logic [31:0] maddr, input logic adc, input logic [31:0] mwd,
                       input logic [1:0] rv, input logic rerr, input logic [31:0] rdata);
        row_t r;
        r = '{rst, v, w, a0, a1, d0, d1, rdy, mrd, mwr, maddr, adc, mwd, rv, rerr, rdata};
        rows.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        reset         = rst;
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
    endtask

    task automatic check_row(input int idx, input row_t r);
        chk("req_ready", idx, 32'(bus.req_ready), 32'(r.rdy));
        chk("mem_read", idx, 32'(mem_read), 32'(r.mrd));
        chk("mem_write", idx, 32'(mem_write), 32'(r.mwr));
        if (!r.adc) begin
            chk("mem_addr", idx, mem_addr, r.maddr);
            chk("mem_wdata", idx, mem_wdata, r.mwd);
        end
        chk("resp_valid", idx, 32'(bus.resp_valid), 32'(r.rv));
        chk("resp_err", idx, 32'(bus.resp_err), 32'(r.rerr));
        chk("resp_rdata", idx, bus.resp_rdata, r.rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);

        //   rst v      w      a0        a1        d0  d1             rdy    mrd   mwr   maddr     adc   mwd            rv     err   rdata
        // reset held two cycles, requests ignored
        add(1'b0, 2'b11, 2'b00, 32'h0,  32'h4,  '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b00, 1'b0, 32'h0);
        add(1'b0, 2'b00, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b00, 1'b0, 32'h0);
        add(1'b1, 2'b00, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b00, 1'b0, 32'h0);
        // contention: alternate grants, responses one cycle behind
        add(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0,            2'b01, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0);
        add(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0,            2'b10, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0,         2'b01, 1'b0, 32'hA500_0004);
        add(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0,            2'b01, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0,         2'b10, 1'b0, 32'hA500_0008);
        add(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0,            2'b10, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0,         2'b01, 1'b0, 32'hA500_0004);
        add(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0,            2'b01, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0,         2'b10, 1'b0, 32'hA500_0008);
        add(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0,            2'b10, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0,         2'b01, 1'b0, 32'hA500_0004);
        add(1'b1, 2'b00, 2'b00, 32'h10, 32'h20, '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b10, 1'b0, 32'hA500_0008);
        // store on port 1 then load same address on port 0
        add(1'b1, 2'b10, 2'b10, 32'h0,  32'h40, '0, 32'hDEADBEEF,  2'b10, 1'b0, 1'b1, 32'h40, 1'b0, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0);
        add(1'b1, 2'b01, 2'b00, 32'h40, 32'h0,  '0, '0,            2'b01, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0);
        add(1'b1, 2'b00, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b01, 1'b0, 32'hDEADBEEF);
        // port 1 load leaves pointer at 1; misaligned port 0 load moves it to 0
        add(1'b1, 2'b10, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b10, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,         2'b00, 1'b0, 32'h0);
        add(1'b1, 2'b01, 2'b00, 32'h42, 32'h0,  '0, '0,            2'b01, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,         2'b10, 1'b0, 32'hA500_0000);
        add(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0,            2'b10, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0,         2'b01, 1'b1, 32'h0);
        add(1'b1, 2'b00, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b10, 1'b0, 32'hA500_0008);
        // misaligned store: no memory write, error pulse on port 1
        add(1'b1, 2'b10, 2'b10, 32'h0,  32'h41, '0, 32'h12345678,  2'b10, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,         2'b00, 1'b0, 32'h0);
        add(1'b1, 2'b00, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b10, 1'b1, 32'h0);
        // port 1 streams four loads with no bubbles
        add(1'b1, 2'b10, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b10, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,         2'b00, 1'b0, 32'h0);
        add(1'b1, 2'b10, 2'b00, 32'h0,  32'h4,  '0, '0,            2'b10, 1'b1, 1'b0, 32'h4,  1'b0, 32'h0,         2'b10, 1'b0, 32'hA500_0000);
        add(1'b1, 2'b10, 2'b00, 32'h0,  32'h8,  '0, '0,            2'b10, 1'b1, 1'b0, 32'h8,  1'b0, 32'h0,         2'b10, 1'b0, 32'hA500_0001);
        add(1'b1, 2'b10, 2'b00, 32'h0,  32'hC,  '0, '0,            2'b10, 1'b1, 1'b0, 32'hC,  1'b0, 32'h0,         2'b10, 1'b0, 32'hA500_0002);
        add(1'b1, 2'b00, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b10, 1'b0, 32'hA500_0003);
        add(1'b1, 2'b00, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b00, 1'b0, 32'h0);
        // word at 0x40 still holds the store; the misaligned store to 0x41 wrote nothing
        add(1'b1, 2'b01, 2'b00, 32'h40, 32'h0,  '0, '0,            2'b01, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0);
        add(1'b1, 2'b00, 2'b00, 32'h0,  32'h0,  '0, '0,            2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         2'b01, 1'b0, 32'hDEADBEEF);

        foreach (rows[i]) begin
            @(posedge clk);
            #1;
            drive(rows[i].rst, rows[i].v, rows[i].w, rows[i].a0, rows[i].a1, rows[i].d0, rows[i].d1);
            @(negedge clk);
            check_row(i, rows[i]);
        end

        // Reset mid-flight: pointer is at 0 here, so without reset a tie would go to port 1.
        @(posedge clk); #1;
        drive(1'b1, 2'b01, 2'b00, 32'h10, 32'h0, '0, '0);
        @(negedge clk);
        chk("mf_accept_ready", 100, 32'(bus.req_ready), 32'h1);
        chk("mf_accept_read", 100, 32'(mem_read), 32'h1);

        @(posedge clk); #1;
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, '0, '0);
        @(negedge clk);
        chk("mf_reset_resp_valid", 101, 32'(bus.resp_valid), 32'h0);
        chk("mf_reset_resp_rdata", 101, bus.resp_rdata, 32'h0);

        @(posedge clk); #1;
        drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, '0, '0);
        @(negedge clk);
        chk("mf_after_resp_valid", 102, 32'(bus.resp_valid), 32'h0);

        @(posedge clk); #1;
        drive(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0);
        @(negedge clk);
        chk("mf_tie_ready", 103, 32'(bus.req_ready), 32'h1);
        chk("mf_tie_addr", 103, mem_addr, 32'h10);

        @(posedge clk); #1;
        drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, '0, '0);
        @(negedge clk);
        chk("mf_tie_resp_valid", 104, 32'(bus.resp_valid), 32'h1);
        chk("mf_tie_resp_rdata", 104, bus.resp_rdata, 32'hA500_0004);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
